// File: rtl/sky_pkg.sv
// Shared constants, colour codes and state encoding for the falling-block game.
package sky_pkg;

    // Playfield and block geometry in pixels; stack capacity in blocks.
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int BLOCK_W    = 32;
    localparam int BLOCK_H    = 16;
    localparam int MAX_BLOCKS = 16;

    // Colour codes; EMPTY marks an unoccupied stack slot and is never spawned.
    localparam logic [1:0] COLOR_EMPTY = 2'd0;
    localparam logic [1:0] COLOR_1     = 2'd1;
    localparam logic [1:0] COLOR_2     = 2'd2;
    localparam logic [1:0] COLOR_3     = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPAWN = 2'd1,
        FALL  = 2'd2,
        WAIT  = 2'd3
    } drop_state_t;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used as a game randomness source.
module lfsr16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic fb;

    assign fb = q[15] ^ q[13] ^ q[12] ^ q[10];

    // Shift every cycle; reload the seed on reset (seed must be nonzero).
    always_ff @(posedge clk) begin
        if (rst) q <= seed;
        else     q <= {q[14:0], fb};
    end

endmodule

// File: rtl/block_dropper.sv
// Spawns a falling block at a random column/colour, moves it down on a divided
// tick, and reports whether it lands on the stack top or falls off the screen.
module block_dropper
    import sky_pkg::*;
#(
    parameter int          TICK_DIV      = 250000,
    parameter int          FALL_STEP     = 2,
    parameter int          RESPAWN_TICKS = 32,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    input  logic [9:0] height,
    output logic [9:0] fall_x,
    output logic [9:0] fall_y,
    output logic [1:0] fall_color,
    output logic       fall_valid,
    output logic       caught,
    output logic       missed,
    output logic       full
);

    localparam int CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WCNT_W    = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;
    localparam int BLK_SHIFT = $clog2(BLOCK_H);
    localparam int SP_W      = 10 + BLK_SHIFT;

    drop_state_t       state, state_nxt;
    logic [CNT_W-1:0]  tick_cnt;
    logic [WCNT_W-1:0] wait_cnt;
    logic              tick, wait_last, stack_full;
    logic [15:0]       lfsr_q;
    logic              lfsr_unused;

    logic [SP_W-1:0]   stack_px;
    logic [9:0]        top_y, land_y, spawn_r, spawn_x;
    logic [1:0]        spawn_col;
    logic [10:0]       ny, adx;
    logic signed [10:0] dx;
    logic              overlap, cross_lo, cross_hi, off_bottom;

    logic [9:0]        fall_x_nxt, fall_y_nxt;
    logic [1:0]        color_nxt;
    logic              valid_nxt, caught_nxt, missed_nxt;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (SEED),
        .q    (lfsr_q)
    );

    // Only the low 12 bits feed spawn position and colour.
    assign lfsr_unused = ^lfsr_q[15:12];

    assign stack_full = (height >= 10'(MAX_BLOCKS));
    assign tick       = ((state == FALL) || (state == WAIT)) &&
                        (tick_cnt == CNT_W'(TICK_DIV - 1));
    assign wait_last  = (wait_cnt == WCNT_W'(RESPAWN_TICKS - 1));

    // Stack top surface; a stack taller than its base position clamps to row 0.
    assign stack_px = SP_W'(height) << BLK_SHIFT;
    assign top_y    = (stack_px > SP_W'(pos_y)) ? '0 : pos_y - stack_px[9:0];
    assign land_y   = (top_y >= 10'(BLOCK_H)) ? top_y - 10'(BLOCK_H) : '0;

    // Spawn column folds out-of-range LFSR values back onto the playfield.
    assign spawn_r   = lfsr_q[9:0];
    assign spawn_x   = (spawn_r <= 10'(SCREEN_W - BLOCK_W)) ? spawn_r : spawn_r - 10'd512;
    assign spawn_col = (lfsr_q[11:10] == COLOR_EMPTY) ? COLOR_1 : lfsr_q[11:10];

    // Landing test: horizontal overlap plus the block bottom crossing the top surface
    // during this step (a block already below the surface is never caught).
    assign ny         = {1'b0, fall_y} + 11'(FALL_STEP);
    assign dx         = $signed({1'b0, fall_x}) - $signed({1'b0, pos_x});
    assign adx        = dx[10] ? -dx : dx;
    assign overlap    = (adx < 11'(BLOCK_W));
    assign cross_lo   = (({1'b0, ny} + 12'(BLOCK_H)) >= {2'b00, top_y});
    assign cross_hi   = (({2'b00, fall_y} + 12'(BLOCK_H)) <= {2'b00, top_y});
    assign off_bottom = (ny >= 11'(SCREEN_H));

    // Next-state and next-output logic; catch takes priority over the bottom edge.
    always_comb begin
        state_nxt  = state;
        fall_x_nxt = fall_x;
        fall_y_nxt = fall_y;
        color_nxt  = fall_color;
        valid_nxt  = fall_valid;
        caught_nxt = 1'b0;
        missed_nxt = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid_nxt = 1'b0;
                    if (!stack_full) state_nxt = SPAWN;
                end
                SPAWN: begin
                    fall_x_nxt = spawn_x;
                    fall_y_nxt = '0;
                    color_nxt  = spawn_col;
                    valid_nxt  = 1'b1;
                    state_nxt  = FALL;
                end
                FALL: begin
                    if (tick) begin
                        if (overlap && cross_lo && cross_hi) begin
                            fall_y_nxt = land_y;
                            caught_nxt = 1'b1;
                            state_nxt  = WAIT;
                        end else if (off_bottom) begin
                            missed_nxt = 1'b1;
                            valid_nxt  = 1'b0;
                            state_nxt  = WAIT;
                        end else begin
                            fall_y_nxt = ny[9:0];
                        end
                    end
                end
                WAIT: begin
                    // A caught block stays visible for the one cycle the stack latches it.
                    valid_nxt = 1'b0;
                    if (tick && wait_last) state_nxt = stack_full ? IDLE : SPAWN;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fall_x     <= '0;
            fall_y     <= '0;
            fall_color <= COLOR_EMPTY;
            fall_valid <= 1'b0;
            caught     <= 1'b0;
            missed     <= 1'b0;
            full       <= 1'b0;
        end else begin
            state      <= state_nxt;
            fall_x     <= fall_x_nxt;
            fall_y     <= fall_y_nxt;
            fall_color <= color_nxt;
            fall_valid <= valid_nxt;
            caught     <= caught_nxt;
            missed     <= missed_nxt;
            full       <= stack_full;
        end
    end

    // Movement tick divider and respawn tick count; both restart on every state change.
    always_ff @(posedge clk) begin
        if (rst || (state_nxt != state)) begin
            tick_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            if (tick) tick_cnt <= '0;
            else if ((state == FALL) || (state == WAIT)) tick_cnt <= tick_cnt + CNT_W'(1);
            if ((state == WAIT) && tick) wait_cnt <= wait_cnt + WCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_block_dropper.sv
// Scoreboard bench for block_dropper: expected landing/miss events are queued
// when each block is steered, and popped when the DUT pulses caught/missed.
module tb_block_dropper;

    localparam int          SCR_W = 640;
    localparam int          SCR_H = 480;
    localparam int          BLK_W = 32;
    localparam int          BLK_H = 16;
    localparam int          STEP  = 2;
    localparam logic [15:0] SEED  = 16'hACE1;

    typedef struct {
        bit is_catch;
        int y;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst, enable;
    logic [9:0] pos_x, pos_y, height;
    logic [9:0] fall_x, fall_y;
    logic [1:0] fall_color;
    logic       fall_valid, caught, missed, full;

    int   n_checks = 0;
    int   n_pass   = 0;
    ev_t  exp_q[$];
    logic [15:0] lfsr_m, lfsr_prev;

    block_dropper #(
        .TICK_DIV      (1),
        .FALL_STEP     (STEP),
        .RESPAWN_TICKS (4),
        .SEED          (SEED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .height     (height),
        .fall_x     (fall_x),
        .fall_y     (fall_y),
        .fall_color (fall_color),
        .fall_valid (fall_valid),
        .caught     (caught),
        .missed     (missed),
        .full       (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference LFSR; lfsr_prev holds the value seen during the previous cycle.
    always @(posedge clk) begin
        lfsr_prev <= lfsr_m;
        if (rst) lfsr_m <= SEED;
        else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    // Outcome of a block spawned at fx falling onto a stack at (px, py, h).
    function automatic ev_t predict(input int fx, input int px, input int py, input int h);
        ev_t e;
        int  top, y, ny;
        bit  ov;
        top = (h * BLK_H > py) ? 0 : py - h * BLK_H;
        ov  = ((fx - px) < BLK_W) && ((px - fx) < BLK_W);
        y = 0;
        e.is_catch = 1'b0;
        e.y = -1;
        for (int k = 0; k < 1000; k++) begin
            ny = y + STEP;
            if (ov && (ny + BLK_H >= top) && (y + BLK_H <= top)) begin
                e.is_catch = 1'b1;
                e.y = (top >= BLK_H) ? top - BLK_H : 0;
                return e;
            end
            if (ny >= SCR_H) begin
                e.y = y;
                return e;
            end
            y = ny;
        end
        return e;
    endfunction

    // Scoreboard consumer: every pulse must match the oldest expected event.
    always @(negedge clk) begin
        ev_t e;
        if (caught || missed) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {caught, missed}, 0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_is_catch", caught, e.is_catch);
                check("pulse_exclusive", caught && missed, 0);
                check("pulse_fall_y", fall_y, e.y);
                check("pulse_valid", fall_valid, e.is_catch);
            end
        end
    end

    // Called at the negedge where fall_valid has just risen.
    task automatic check_spawn(input string name);
        logic [9:0] r;
        int ex, ec;
        r  = lfsr_prev[9:0];
        ex = (r <= 10'(SCR_W - BLK_W)) ? int'(r) : int'(r) - 512;
        ec = (lfsr_prev[11:10] == 2'd0) ? 1 : int'(lfsr_prev[11:10]);
        check({name, "_x"}, fall_x, ex);
        check({name, "_color"}, fall_color, ec);
        check({name, "_y0"}, fall_y, 0);
        check({name, "_x_range"}, int'(fall_x <= 10'd608), 1);
        check({name, "_color_range"}, int'(fall_color != 2'd0), 1);
    endtask

    task automatic wait_valid(input string name, input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (fall_valid) break;
        end
        check(name, fall_valid, 1);
    endtask

    // Steer the freshly spawned block, follow its fall, then check the respawn gap.
    task automatic run_drop(input string name, input int off, input int py, input int h);
        ev_t e;
        int  y_exp, c;
        bit  hit;
        pos_y  = 10'(py);
        height = 10'(h);
        pos_x  = 10'(int'(fall_x) + off);
        e = predict(fall_x, int'(fall_x) + off, py, h);
        exp_q.push_back(e);
        y_exp = 0;
        hit   = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (caught || missed) begin
                hit = 1'b1;
                break;
            end
            y_exp += STEP;
            check({name, "_fall_y"}, fall_y, y_exp);
        end
        check({name, "_pulse_seen"}, hit, 1);
        @(negedge clk);
        check({name, "_valid_dropped"}, fall_valid, 0);
        check({name, "_single_pulse"}, caught || missed, 0);
        check({name, "_sb_drained"}, exp_q.size(), 0);
        c = 1;
        for (int k = 0; k < 20; k++) begin
            if (fall_valid) break;
            @(negedge clk);
            c++;
        end
        check({name, "_respawn_gap"}, c, 5);
        check_spawn({name, "_respawn"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        pos_x  = '0;
        pos_y  = 10'd464;
        height = '0;
        @(negedge clk);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_fall_x", fall_x, 0);
        check("rst_fall_y", fall_y, 0);
        check("rst_color", fall_color, 0);
        check("rst_valid", fall_valid, 0);
        check("rst_caught", caught, 0);
        check("rst_missed", missed, 0);
        check("rst_full", full, 0);
        repeat (5) @(negedge clk);
        check("idle_valid", fall_valid, 0);

        enable = 1'b1;
        wait_valid("first_spawn", 4);
        check_spawn("spawn0");

        run_drop("catch_empty", 0, 464, 0);
        run_drop("miss", 40, 464, 0);
        run_drop("edge31", 31, 464, 3);
        run_drop("edge32", 32, 464, 3);

        // Full stack blocks spawning until height drops below capacity.
        enable = 1'b0;
        height = 10'd16;
        repeat (2) @(negedge clk);
        check("full_set", full, 1);
        enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("full_no_spawn", fall_valid, 0);
        end
        height = 10'd15;
        wait_valid("unfull_spawn", 2);
        check("full_cleared", full, 0);
        check_spawn("unfull");

        // Many spawns via enable toggling: position and colour each time.
        height = '0;
        pos_y  = 10'd464;
        for (int i = 0; i < 1000; i++) begin
            enable = 1'b0;
            @(negedge clk);
            enable = 1'b1;
            wait_valid("range_spawn", 4);
            check_spawn("range");
        end

        // Reset during a fall returns everything to reset values without a pulse.
        pos_x = 10'(int'(fall_x) + 100);
        repeat (10) @(negedge clk);
        check("midfall_valid", fall_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_fall_x", fall_x, 0);
        check("midrst_fall_y", fall_y, 0);
        check("midrst_color", fall_color, 0);
        check("midrst_valid", fall_valid, 0);
        check("midrst_caught", caught, 0);
        check("midrst_missed", missed, 0);
        check("midrst_full", full, 0);
        repeat (2) @(negedge clk);
        enable = 1'b0;
        rst    = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_valid", fall_valid, 0);
        check("post_rst_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
